// File: rtl/product_accumulator_pkg.sv
// Shared defaults for the multiplier datapath and its product accumulator.
// Holds operand width, pipeline depth, group size and a clog2 helper.
package product_accumulator_pkg;

  localparam int SIZE_D  = 8;
  localparam int LEVEL_D = 4;
  localparam int COUNT_D = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/product_accumulator_valid_delay.sv
// valid_delay: DEPTH-stage shift register that tracks operand validity
// alongside the upstream multiplier pipeline.
// Ports: clk, rst (async, active-high), clear (sync flush),
//        valid (in), delayed (valid after DEPTH edges).
module valid_delay #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic valid,
  output logic delayed
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else begin
      sr[0] <= valid;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign delayed = sr[DEPTH-1];

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums groups of COUNT products from a pipelined
// multiplier and hands each group sum out through a one-slot register.
// Ports: clk, rst (async, active-high), op_valid, pdt, clear,
//        sum/sum_valid/sum_ready (output slot), grp_cnt, overrun (sticky).
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter  int SIZE  = SIZE_D,
  parameter  int LEVEL = LEVEL_D,
  parameter  int COUNT = COUNT_D,
  localparam int CNT_W = clog2(COUNT),
  localparam int ACC_W = 2*SIZE + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2*SIZE-1:0] pdt,
  input  logic             clear,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [CNT_W-1:0] grp_cnt,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  logic             pdt_vld;
  logic             hs;
  logic             done;
  logic             load;
  logic [ACC_W-1:0] pdt_ext;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;

  valid_delay #(
    .DEPTH(LEVEL + 1)
  ) u_valid_delay (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .valid  (op_valid),
    .delayed(pdt_vld)
  );

  assign pdt_ext = ACC_W'(pdt);
  assign hs      = sum_valid & sum_ready;
  assign done    = pdt_vld && (grp_cnt == LAST);
  // A finished group fits if the slot is empty or drains this edge.
  assign load    = done && (!sum_valid || hs);
  // First product of a group restarts the sum instead of adding.
  assign acc_nxt = (grp_cnt == '0) ? pdt_ext : acc + pdt_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      grp_cnt <= '0;
    end else if (clear) begin
      acc     <= '0;
      grp_cnt <= '0;
    end else if (pdt_vld) begin
      acc     <= acc_nxt;
      grp_cnt <= done ? '0 : grp_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      sum_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      sum_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        sum       <= acc_nxt;
        sum_valid <= 1'b1;
      end else if (hs) begin
        sum_valid <= 1'b0;
      end
      if (done && !load) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator with a behavioural pipelined multiplier.
// Expected sums are queued at stimulus time and popped on each handshake.
module tb_product_accumulator;

  localparam int LEVEL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        clear;
  logic        sum_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] pdt;
  logic [17:0] sum;
  logic        sum_valid;
  logic [1:0]  grp_cnt;
  logic        overrun;

  logic [15:0] mp [LEVEL+1];
  logic [17:0] exp_q [$];
  logic [17:0] e;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mp[0] <= 16'(a) * 16'(b);
    for (int i = 1; i <= LEVEL; i++) mp[i] <= mp[i-1];
  end
  assign pdt = mp[LEVEL];

  product_accumulator dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .pdt      (pdt),
    .clear    (clear),
    .sum      (sum),
    .sum_valid(sum_valid),
    .sum_ready(sum_ready),
    .grp_cnt  (grp_cnt),
    .overrun  (overrun)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && sum_valid && sum_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sum_unexpected: got %0d expected none", sum);
      end else begin
        e = exp_q.pop_front();
        if (sum !== e) begin
          miscompares++;
          $display("FAIL sum: got %0d expected %0d", sum, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    op_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic ops(int n, logic [7:0] x, logic [7:0] y);
    for (int i = 0; i < n; i++) begin
      a = x;
      b = y;
      op_valid = 1'b1;
      tick();
    end
    op_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    op_valid = 1'b0;
    clear = 1'b0;
    sum_ready = 1'b1;
    a = '0;
    b = '0;
    #1;
    chk("rst_sum", sum, 0);
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_grp_cnt", grp_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // max-value group, sum_valid must pulse exactly at cycle 9
    exp_q.push_back(18'd260100);
    for (int c = 0; c <= 12; c++) begin
      op_valid = (c < 4);
      a = 8'd255;
      b = 8'd255;
      @(negedge clk);
      chk($sformatf("max_sum_valid_c%0d", c), sum_valid, (c == 9));
      tick();
    end

    // gapped input
    exp_q.push_back(18'd100);
    for (int i = 0; i < 4; i++) begin
      a = 8'(2*i + 1);
      b = 8'(2*i + 2);
      op_valid = 1'b1;
      tick();
      idle(5);
      @(negedge clk);
      chk($sformatf("gap_grp_cnt_%0d", i), grp_cnt, (i + 1) % 4);
      tick();
    end
    idle(2);

    // backpressure: 24 held, 80 dropped
    sum_ready = 1'b0;
    exp_q.push_back(18'd24);
    ops(4, 8'd2, 8'd3);
    ops(4, 8'd4, 8'd5);
    idle(8);
    @(negedge clk);
    chk("bp_sum_valid", sum_valid, 1);
    chk("bp_sum_held", sum, 24);
    chk("bp_overrun", overrun, 1);
    chk("bp_grp_cnt", grp_cnt, 0);
    tick();
    sum_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_after_pop_valid", sum_valid, 0);
    chk("bp_after_pop_overrun", overrun, 1);
    tick();

    // clear after two products with two more in flight
    for (int c = 0; c <= 12; c++) begin
      op_valid = (c < 4);
      a = 8'd3;
      b = 8'd3;
      clear = (c == 7);
      @(negedge clk);
      if (c == 7) chk("clr_pre_grp_cnt", grp_cnt, 2);
      if (c == 8) begin
        chk("clr_grp_cnt", grp_cnt, 0);
        chk("clr_overrun", overrun, 0);
      end
      if (c == 12) begin
        chk("clr_late_grp_cnt", grp_cnt, 0);
        chk("clr_late_sum_valid", sum_valid, 0);
      end
      tick();
    end
    clear = 1'b0;
    exp_q.push_back(18'd4);
    ops(4, 8'd1, 8'd1);
    idle(10);

    // pop and completion on the same edge
    sum_ready = 1'b0;
    exp_q.push_back(18'd4);
    ops(4, 8'd1, 8'd1);
    idle(8);
    exp_q.push_back(18'd16);
    for (int c = 0; c <= 10; c++) begin
      op_valid = (c < 4);
      a = 8'd2;
      b = 8'd2;
      sum_ready = (c == 8);
      @(negedge clk);
      if (c == 9) begin
        chk("sim_sum_valid", sum_valid, 1);
        chk("sim_sum", sum, 16);
        chk("sim_overrun", overrun, 0);
      end
      tick();
    end
    sum_ready = 1'b1;
    idle(3);

    // asynchronous reset mid-stream
    sum_ready = 1'b0;
    ops(8, 8'd1, 8'd2);
    idle(8);
    chk("mrst_pre_overrun", overrun, 1);
    for (int i = 0; i < 7; i++) begin
      a = 8'd3;
      b = 8'd3;
      op_valid = 1'b1;
      tick();
    end
    chk("mrst_pre_grp_cnt", grp_cnt, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_sum", sum, 0);
    chk("mrst_sum_valid", sum_valid, 0);
    chk("mrst_overrun", overrun, 0);
    chk("mrst_grp_cnt", grp_cnt, 0);
    op_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sum_ready = 1'b1;
    idle(6);
    chk("mrst_flush_grp_cnt", grp_cnt, 0);
    chk("mrst_flush_sum_valid", sum_valid, 0);
    exp_q.push_back(18'd16);
    ops(4, 8'd2, 8'd2);
    idle(10);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
